// File: rtl/seven_seg_sched.sv
// seven_seg_sched: chooses which shadowed 32-bit debug word feeds the seven_seg driver,
// rotating on a dwell timer or stepping on a pushbutton edge, with a freeze hold.
module seven_seg_sched #(
  parameter int NSRC  = 4,
  parameter int DWELL = 50_000_000,
  parameter int SW    = $clog2(NSRC)
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [NSRC*32-1:0]  i_src_value,
  input  logic [NSRC-1:0]     i_src_upd,
  input  logic                i_auto,
  input  logic                i_next,
  input  logic                i_freeze,
  output logic [31:0]         o_disp_value,
  output logic                o_disp_en,
  output logic [SW-1:0]       o_sel
);

  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

  logic [31:0]   r_shadow [NSRC];
  logic [NSRC-1:0] r_valid;
  logic          r_next_q;
  logic          r_frz_q;
  logic [CW-1:0] r_cnt;
  logic [SW-1:0] r_sel;
  logic [31:0]   r_disp_value;
  logic          r_disp_en;

  logic          w_next_edge;
  logic          w_dwell_hit;
  logic          w_step;
  logic [SW-1:0] w_cand;
  logic [SW-1:0] w_scan_sel;
  logic [SW-1:0] w_new_sel;
  logic          w_upd_new;
  logic [31:0]   w_load_word;
  logic          w_load;

  assign w_next_edge = i_next & ~r_next_q;
  assign w_dwell_hit = i_auto & (r_cnt == LAST);
  assign w_step      = w_dwell_hit | w_next_edge;

  // Descending scan so the nearest valid index after r_sel is the one that sticks.
  always_comb begin
    w_scan_sel = r_sel;
    w_cand     = '0;
    for (int k = NSRC - 1; k >= 1; k--) begin
      w_cand = SW'((int'(r_sel) + k) % NSRC);
      if (r_valid[w_cand]) w_scan_sel = w_cand;
    end
  end

  assign w_new_sel = w_step ? w_scan_sel : r_sel;

  // A source updating this very cycle is shown from its input, not the stale shadow.
  always_comb begin
    w_upd_new   = 1'b0;
    w_load_word = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (w_new_sel == SW'(i)) begin
        w_upd_new   = i_src_upd[i];
        w_load_word = i_src_upd[i] ? i_src_value[32*i +: 32] : r_shadow[i];
      end
    end
  end

  assign w_load = (w_new_sel != r_sel) | w_upd_new | r_frz_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NSRC; i++) r_shadow[i] <= '0;
      r_valid      <= NSRC'(1);
      r_next_q     <= 1'b0;
      r_frz_q      <= 1'b0;
      r_cnt        <= '0;
      r_sel        <= '0;
      r_disp_value <= '0;
      r_disp_en    <= 1'b0;
    end else begin
      for (int i = 0; i < NSRC; i++) begin
        if (i_src_upd[i]) r_shadow[i] <= i_src_value[32*i +: 32];
      end
      r_valid  <= r_valid | i_src_upd;
      r_next_q <= i_next;
      r_frz_q  <= i_freeze;
      if (i_freeze) begin
        r_disp_en <= 1'b0;
      end else begin
        if (w_next_edge || !i_auto || (r_cnt == LAST)) r_cnt <= '0;
        else r_cnt <= r_cnt + CW'(1);
        r_sel     <= w_new_sel;
        r_disp_en <= w_load;
        if (w_load) r_disp_value <= w_load_word;
      end
    end
  end

  assign o_disp_value = r_disp_value;
  assign o_disp_en    = r_disp_en;
  assign o_sel        = r_sel;

endmodule

// File: tb/tb_seven_seg_sched.sv
// tb_seven_seg_sched: directed scenarios plus randomized traffic, all checked every
// cycle against a plain-arithmetic model of the scheduler's selection rules.
module tb_seven_seg_sched;

  localparam int NSRC  = 4;
  localparam int DWELL = 4;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [NSRC*32-1:0] srcValue = '0;
  logic [NSRC-1:0]    srcUpd = '0;
  logic               autoEn = 1'b0;
  logic               nextReq = 1'b0;
  logic               freeze = 1'b0;
  logic [31:0]        dispValue;
  logic               dispEn;
  logic [1:0]         sel;

  int compared = 0;
  int mismatched = 0;

  seven_seg_sched #(.NSRC(NSRC), .DWELL(DWELL)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_src_value  (srcValue),
    .i_src_upd    (srcUpd),
    .i_auto       (autoEn),
    .i_next       (nextReq),
    .i_freeze     (freeze),
    .o_disp_value (dispValue),
    .o_disp_en    (dispEn),
    .o_sel        (sel)
  );

  always #5 clk = ~clk;

  // Reference model: what should be on the outputs after each edge.
  int          mSel = 0;
  int          mCnt = 0;
  logic [31:0] mVal = '0;
  bit          mEn = 1'b0;
  bit          mPrevNext = 1'b0;
  bit          mPrevFrz = 1'b0;
  logic [31:0] mShadow [NSRC];
  bit          mValid [NSRC];

  always @(posedge clk or negedge rst_n) begin
    int target;
    bit found;
    bit edgeSeen;
    bit wantStep;
    if (!rst_n) begin
      mSel = 0; mCnt = 0; mVal = '0; mEn = 1'b0;
      mPrevNext = 1'b0; mPrevFrz = 1'b0;
      for (int i = 0; i < NSRC; i++) begin
        mShadow[i] = '0;
        mValid[i] = (i == 0);
      end
    end else begin
      edgeSeen = nextReq && !mPrevNext;
      if (!freeze) begin
        wantStep = edgeSeen || (autoEn && mCnt == DWELL - 1);
        target = mSel;
        found = 1'b0;
        if (wantStep) begin
          for (int k = 1; k < NSRC; k++) begin
            if (!found && mValid[(mSel + k) % NSRC]) begin
              target = (mSel + k) % NSRC;
              found = 1'b1;
            end
          end
        end
        mCnt = (edgeSeen || !autoEn) ? 0 : (mCnt + 1) % DWELL;
        mEn = (target != mSel) || srcUpd[target] || mPrevFrz;
        if (mEn) mVal = srcUpd[target] ? srcValue[32*target +: 32] : mShadow[target];
        mSel = target;
      end else begin
        mEn = 1'b0;
      end
      for (int i = 0; i < NSRC; i++) begin
        if (srcUpd[i]) begin
          mShadow[i] = srcValue[32*i +: 32];
          mValid[i] = 1'b1;
        end
      end
      mPrevNext = nextReq;
      mPrevFrz = freeze;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  // Per-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    checkOutput("sel", 32'(sel), 32'(mSel));
    checkOutput("disp_en", 32'(dispEn), 32'(mEn));
    checkOutput("disp_value", dispValue, mVal);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [NSRC-1:0] upd, input logic a, input logic n, input logic f);
    srcUpd = upd;
    autoEn = a;
    nextReq = n;
    freeze = f;
  endtask

  task automatic setWord(input int idx, input logic [31:0] w);
    srcValue[32*idx +: 32] = w;
  endtask

  task automatic doReset();
    applyStimulus('0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  int sCycle[$];
  int sSel[$];
  logic [31:0] sVal[$];

  task automatic collectStrobes(input int n);
    sCycle.delete(); sSel.delete(); sVal.delete();
    for (int c = 0; c < n; c++) begin
      step();
      if (dispEn) begin
        sCycle.push_back(c);
        sSel.push_back(int'(sel));
        sVal.push_back(dispValue);
      end
    end
  endtask

  initial begin
    int strobes;
    int cycles;
    bit found;

    // Reset held with random inputs.
    for (int c = 0; c < 8; c++) begin
      step();
      srcValue = {$urandom, $urandom, $urandom, $urandom};
      applyStimulus(NSRC'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      #2;
      checkOutput("reset_sel", 32'(sel), 32'd0);
      checkOutput("reset_en", 32'(dispEn), 32'd0);
      checkOutput("reset_value", dispValue, 32'd0);
    end
    applyStimulus('0, 1'b0, 1'b0, 1'b0);
    step();
    rst_n = 1'b1;
    strobes = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (dispEn) strobes++;
    end
    checkOutput("no_strobe_after_reset", strobes, 0);

    // Auto rotation over four valid sources.
    doReset();
    autoEn = 1'b1;
    for (int i = 0; i < NSRC; i++) begin
      setWord(i, 32'h11111111 * (i + 1));
      srcUpd = NSRC'(1 << i);
      step();
    end
    srcUpd = '0;
    step();
    collectStrobes(30);
    checkOutput("auto_count", 32'(sSel.size() >= 5), 32'd1);
    if (sSel.size() >= 5) begin
      for (int k = 1; k < 5; k++) begin
        checkOutput("auto_gap", sCycle[k] - sCycle[k-1], 4);
        checkOutput("auto_sel", sSel[k], (sSel[k-1] + 1) % 4);
      end
      for (int k = 0; k < 5; k++) checkOutput("auto_word", sVal[k], 32'h11111111 * (sSel[k] + 1));
    end

    // Only source 2 valid: rotation alternates 0 and 2.
    doReset();
    autoEn = 1'b1;
    setWord(2, 32'hCAFEF00D);
    srcUpd = 4'b0100;
    step();
    srcUpd = '0;
    step();
    step();
    collectStrobes(20);
    checkOutput("skip_count", 32'(sSel.size() >= 4), 32'd1);
    if (sSel.size() >= 4) begin
      for (int k = 0; k < 4; k++) begin
        checkOutput("skip_word", sVal[k], (sSel[k] == 2) ? 32'hCAFEF00D : 32'd0);
        if (k > 0) begin
          checkOutput("skip_sel", sSel[k], (sSel[k-1] == 0) ? 2 : 0);
          checkOutput("skip_gap", sCycle[k] - sCycle[k-1], 4);
        end
      end
    end

    // Manual step with NEXT held, then step plus same-cycle update bypass.
    doReset();
    for (int i = 0; i < NSRC; i++) begin
      setWord(i, 32'hA0000000 + i);
      srcUpd = NSRC'(1 << i);
      step();
    end
    srcUpd = '0;
    step();
    checkOutput("manual_start_sel", 32'(sel), 32'd0);
    nextReq = 1'b1;
    strobes = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (dispEn) strobes++;
    end
    checkOutput("manual_one_step", strobes, 1);
    checkOutput("manual_sel", 32'(sel), 32'd1);
    nextReq = 1'b0;
    step();
    nextReq = 1'b1;
    setWord(2, 32'hDEADBEEF);
    srcUpd = 4'b0100;
    step();
    srcUpd = '0;
    checkOutput("bypass_sel", 32'(sel), 32'd2);
    checkOutput("bypass_en", 32'(dispEn), 32'd1);
    checkOutput("bypass_value", dispValue, 32'hDEADBEEF);

    // Freeze holds everything, release refreshes with the captured word.
    freeze = 1'b1;
    nextReq = 1'b0;
    step();
    setWord(2, 32'h12345678);
    srcUpd = 4'b0100;
    nextReq = 1'b1;
    step();
    checkOutput("freeze_en", 32'(dispEn), 32'd0);
    checkOutput("freeze_sel", 32'(sel), 32'd2);
    checkOutput("freeze_value", dispValue, 32'hDEADBEEF);
    srcUpd = '0;
    step();
    checkOutput("freeze_en2", 32'(dispEn), 32'd0);
    checkOutput("freeze_value2", dispValue, 32'hDEADBEEF);
    freeze = 1'b0;
    step();
    checkOutput("thaw_en", 32'(dispEn), 32'd1);
    checkOutput("thaw_sel", 32'(sel), 32'd2);
    checkOutput("thaw_value", dispValue, 32'h12345678);
    step();
    checkOutput("thaw_single", 32'(dispEn), 32'd0);
    nextReq = 1'b0;

    // Asynchronous reset mid-dwell at SEL=3, counter=2.
    doReset();
    for (int i = 0; i < NSRC; i++) begin
      setWord(i, 32'hB0000000 + i);
      srcUpd = NSRC'(1 << i);
      step();
    end
    srcUpd = '0;
    autoEn = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      step();
      if (sel == 2'd3 && mCnt == 2) found = 1'b1;
    end
    checkOutput("reach_sel3_cnt2", 32'(found), 32'd1);
    if (found) begin
      #1 rst_n = 1'b0;
      #1;
      checkOutput("async_sel", 32'(sel), 32'd0);
      checkOutput("async_en", 32'(dispEn), 32'd0);
      checkOutput("async_value", dispValue, 32'd0);
      #1 rst_n = 1'b1;
      for (int i = 1; i < NSRC; i++) setWord(i, 32'hC0000000 + i);
      srcUpd = 4'b1110;
      cycles = 0;
      found = 1'b0;
      for (int c = 0; c < 20 && !found; c++) begin
        step();
        srcUpd = '0;
        cycles++;
        if (dispEn) found = 1'b1;
      end
      checkOutput("restart_gap", cycles, 4);
      checkOutput("restart_sel", 32'(sel), 32'd1);
      checkOutput("restart_value", dispValue, 32'hC0000001);
      cycles = 0;
      found = 1'b0;
      for (int c = 0; c < 20 && !found; c++) begin
        step();
        cycles++;
        if (dispEn) found = 1'b1;
      end
      checkOutput("restart_gap2", cycles, 4);
      checkOutput("restart_sel2", 32'(sel), 32'd2);
    end

    // Randomized traffic, including short asynchronous reset pulses.
    doReset();
    for (int c = 0; c < 3000; c++) begin
      step();
      srcValue = {$urandom, $urandom, $urandom, $urandom};
      srcUpd = ($urandom_range(0, 3) == 0) ? NSRC'($urandom) : '0;
      autoEn = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 4) == 0) nextReq = ~nextReq;
      if ($urandom_range(0, 7) == 0) freeze = ~freeze;
      if ($urandom_range(0, 299) == 0) begin
        #1 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
    end
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
